// File: rtl/bus_xfer_sequencer_pkg.sv
// Shared types and constants for the register-bus transfer sequencer.
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LATCH  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int DEF_SETTLE_CYCLES = 1;
    localparam int CNT_W             = 4;

    // Width of a full one-hot decode of an idx_w-bit index.
    function automatic int onehot_width(input int idx_w);
        return 1 << idx_w;
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_onehot_decoder.sv
// Index to one-hot decoder with enable; out-of-range indices decode to all zeros.
module onehot_decoder
    import bus_xfer_pkg::*;
#(
    parameter int IDX_W    = 2,
    parameter int NUM_REGS = 4
) (
    input  logic                en_i,
    input  logic [IDX_W-1:0]    idx_i,
    output logic [NUM_REGS-1:0] onehot_o
);

    logic [onehot_width(IDX_W)-1:0] full;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        full        = '0;
        full[idx_i] = en_i;
        onehot_o    = full[NUM_REGS-1:0];
    end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Register-bus transfer sequencer: drives one source onto the bus, settles, then loads one destination.
// Optional macro XFER_COUNT_EN adds an 8-bit completed-transfer counter output xfer_count.
module bus_xfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS      = 4,
    parameter int IDX_W         = 2,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_src,
    input  logic [IDX_W-1:0]    req_dst,
    input  logic                req_src_ext,
    output logic [NUM_REGS-1:0] data_out_en,
    output logic [NUM_REGS-1:0] data_in_en,
    output logic                busy,
    output logic                done,
    output logic                err
`ifdef XFER_COUNT_EN
    ,
    output logic [7:0]          xfer_count
`endif
);

    state_e             state_q;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   dst_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               drive_on_q;
    logic               load_on_q;
    logic               done_q;
    logic               err_q;
    logic               req_bad;

    // An external source skips the source checks: it may alias any index.
    always_comb begin
        req_bad = (int'(req_dst) >= NUM_REGS) ||
                  (!req_src_ext && ((int'(req_src) >= NUM_REGS) || (req_src == req_dst)));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= '0;
            drive_on_q <= 1'b0;
            load_on_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (req_valid) begin
                        if (req_bad) begin
                            err_q <= 1'b1;
                        end else begin
                            src_q      <= req_src;
                            dst_q      <= req_dst;
                            drive_on_q <= !req_src_ext;
                            if (SETTLE_CYCLES > 0) begin
                                state_q <= ST_SETTLE;
                                cnt_q   <= CNT_W'(SETTLE_CYCLES);
                            end else begin
                                state_q   <= ST_LATCH;
                                load_on_q <= 1'b1;
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q   <= ST_LATCH;
                        load_on_q <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    drive_on_q <= 1'b0;
                    load_on_q  <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign err       = err_q;

    onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_drive_dec (
        .en_i     (drive_on_q),
        .idx_i    (src_q),
        .onehot_o (data_out_en)
    );

    onehot_decoder #(.IDX_W(IDX_W), .NUM_REGS(NUM_REGS)) u_load_dec (
        .en_i     (load_on_q),
        .idx_i    (dst_q),
        .onehot_o (data_in_en)
    );

`ifdef XFER_COUNT_EN
    logic [7:0] xfer_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_count_q <= '0;
        end else if (done_q) begin
            xfer_count_q <= xfer_count_q + 8'd1;
        end
    end

    assign xfer_count = xfer_count_q;
`endif

endmodule
